// File: rtl/arith_pkg.sv
// Shared arithmetic constants and the pipeline-depth helper for the CLA adder.
package arith_pkg;

   localparam int DEF_WIDTH       = 16;
   localparam int DEF_GROUP_WIDTH = 4;

   // Number of look-ahead groups in a word; 0 marks a width that does not split evenly.
   function automatic int calc_stages(input int width, input int group_width);
      int stages;
      if (group_width <= 0 || width <= 0 || (width % group_width) != 0)
         stages = 0;
      else
         stages = width / group_width;
      return stages;
   endfunction

endpackage

// File: rtl/cla_group.sv
// One look-ahead carry group: sum of a GROUP_WIDTH slice with every carry
// expanded to two-level generate/propagate logic (no internal ripple).
module cla_group
   import arith_pkg::*;
#(
   parameter int GROUP_WIDTH = DEF_GROUP_WIDTH
) (
   input  logic [GROUP_WIDTH-1:0] a,
   input  logic [GROUP_WIDTH-1:0] b,
   input  logic                   cin,
   output logic [GROUP_WIDTH-1:0] sum,
   output logic                   cout,
   output logic                   cmsb
);

   logic [GROUP_WIDTH-1:0] p, g;
   logic [GROUP_WIDTH:0]   c;
   logic                   term;

   assign p = a ^ b;
   assign g = a & b;

   // c[i+1] = cin&p[0..i] | g[0]&p[1..i] | ... | g[i], built as a flat sum of products.
   always_comb begin
      c    = '0;
      term = 1'b0;
      c[0] = cin;
      for (int i = 0; i < GROUP_WIDTH; i++) begin
         term = cin;
         for (int m = 0; m <= i; m++) term = term & p[m];
         c[i+1] = term;
         for (int j = 0; j <= i; j++) begin
            term = g[j];
            for (int m = j + 1; m <= i; m++) term = term & p[m];
            c[i+1] = c[i+1] | term;
         end
      end
   end

   assign sum  = p ^ c[GROUP_WIDTH-1:0];
   assign cout = c[GROUP_WIDTH];
   assign cmsb = c[GROUP_WIDTH-1];

endmodule

// File: rtl/cla_adder_pipelined.sv
// Pipelined add/subtract: one look-ahead group per stage, the group carry
// registered between stages, operands skewed forward and sum bits deskewed.
module cla_adder_pipelined
   import arith_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int GROUP_WIDTH = DEF_GROUP_WIDTH
) (
   input  logic             Clock_In,
   input  logic             Reset_n_In,
   input  logic             Enable_In,
   input  logic             Valid_In,
   output logic             Ready_Out,
   input  logic [WIDTH-1:0] Data_A_In,
   input  logic [WIDTH-1:0] Data_B_In,
   input  logic             Carry_In,
   input  logic             Sub_In,
   output logic             Valid_Out,
   input  logic             Ready_In,
   output logic [WIDTH-1:0] Sum_Out,
   output logic             Carry_Out,
   output logic             Overflow_Out
);

   localparam int STAGES = calc_stages(WIDTH, GROUP_WIDTH);

   if (STAGES == 0) begin : g_bad_split
      $error("cla_adder_pipelined: WIDTH must be a non-zero multiple of GROUP_WIDTH");
   end

   // Stage k registers hold the state leaving stage k; index STAGES-1 is the output.
   logic                            advance;
   logic [STAGES-1:0]               vld_pipe, vld_st;
   logic [STAGES-1:0][WIDTH-1:0]    a_q, b_q, s_q;
   logic [STAGES-1:0]               c_q;
   logic                            ovf_q;
   logic [STAGES-1:0][WIDTH-1:0]    a_st, b_st, s_st, s_nx;
   logic [STAGES-1:0]               c_st;
   logic [STAGES-1:0][GROUP_WIDTH-1:0] grp_sum;
   logic [STAGES-1:0]               grp_cout, grp_cmsb;
   logic                            unused_bits;

   // Global stall: everything moves only when the output slot is free or being drained.
   assign advance   = Enable_In & (~Valid_Out | Ready_In);
   assign Ready_Out = advance;

   // Stage inputs: stage 0 takes the port operands (B inverted for subtract), later stages their predecessor.
   always_comb begin
      vld_st    = '0;
      a_st      = '0;
      b_st      = '0;
      s_st      = '0;
      c_st      = '0;
      vld_st[0] = Valid_In;
      a_st[0]   = Data_A_In;
      b_st[0]   = Data_B_In ^ {WIDTH{Sub_In}};
      c_st[0]   = Carry_In ^ Sub_In;
      for (int k = 1; k < STAGES; k++) begin
         vld_st[k] = vld_pipe[k-1];
         a_st[k]   = a_q[k-1];
         b_st[k]   = b_q[k-1];
         s_st[k]   = s_q[k-1];
         c_st[k]   = c_q[k-1];
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      cla_group #(.GROUP_WIDTH(GROUP_WIDTH)) u_grp (
         .a    (a_st[k][k*GROUP_WIDTH +: GROUP_WIDTH]),
         .b    (b_st[k][k*GROUP_WIDTH +: GROUP_WIDTH]),
         .cin  (c_st[k]),
         .sum  (grp_sum[k]),
         .cout (grp_cout[k]),
         .cmsb (grp_cmsb[k])
      );
   end

   // Each stage drops its freshly resolved group into the partially built sum.
   always_comb begin
      s_nx = s_st;
      for (int k = 0; k < STAGES; k++) s_nx[k][k*GROUP_WIDTH +: GROUP_WIDTH] = grp_sum[k];
   end

   // Pipeline registers; overflow is formed at the last group and kept alongside the sum.
   always_ff @(posedge Clock_In or negedge Reset_n_In) begin
      if (!Reset_n_In) begin
         vld_pipe <= '0;
         a_q      <= '0;
         b_q      <= '0;
         s_q      <= '0;
         c_q      <= '0;
         ovf_q    <= 1'b0;
      end else if (advance) begin
         vld_pipe <= vld_st;
         a_q      <= a_st;
         b_q      <= b_st;
         s_q      <= s_nx;
         c_q      <= grp_cout;
         ovf_q    <= grp_cout[STAGES-1] ^ grp_cmsb[STAGES-1];
      end
   end

   assign Valid_Out    = vld_pipe[STAGES-1];
   assign Sum_Out      = s_q[STAGES-1];
   assign Carry_Out    = c_q[STAGES-1];
   assign Overflow_Out = ovf_q;

   // Operand copies leaving the last stage and carries-into-MSB of inner groups have no consumer.
   assign unused_bits = ^{a_q[STAGES-1], b_q[STAGES-1], grp_cmsb};

endmodule

// File: tb/tb_cla_adder_pipelined.sv
// Scoreboard bench: accepted ops are pushed with a reference result, a negedge
// monitor pops and compares on every consumed output and checks stall holds.
module tb_cla_adder_pipelined;

   localparam int W  = 16;
   localparam int ST = 4;

   logic          Clock_In, Reset_n_In, Enable_In, Valid_In, Ready_Out;
   logic [W-1:0]  Data_A_In, Data_B_In, Sum_Out;
   logic          Carry_In, Sub_In, Valid_Out, Ready_In, Carry_Out, Overflow_Out;

   cla_adder_pipelined #(.WIDTH(W), .GROUP_WIDTH(4)) dut (
      .Clock_In     (Clock_In),
      .Reset_n_In   (Reset_n_In),
      .Enable_In    (Enable_In),
      .Valid_In     (Valid_In),
      .Ready_Out    (Ready_Out),
      .Data_A_In    (Data_A_In),
      .Data_B_In    (Data_B_In),
      .Carry_In     (Carry_In),
      .Sub_In       (Sub_In),
      .Valid_Out    (Valid_Out),
      .Ready_In     (Ready_In),
      .Sum_Out      (Sum_Out),
      .Carry_Out    (Carry_Out),
      .Overflow_Out (Overflow_Out)
   );

   typedef struct {
      logic [W-1:0] sum;
      logic         cy;
      logic         ov;
      int           stamp;
   } exp_t;

   exp_t          sbq[$];
   exp_t          mon_e;
   int            n_chk = 0;
   int            n_fail = 0;
   int            cyc = 0;
   bit            lat_chk = 0;
   bit            exp_rdy = 0;
   bit            rst_evt = 0;
   bit            done = 0;
   bit            frozen_prev = 0;
   logic [W-1:0]  hold_sum;
   logic          hold_vld, hold_cy, hold_ov;

   initial Clock_In = 1'b0;
   always #5 Clock_In = ~Clock_In;

   always @(posedge Clock_In) cyc++;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, got time %0t, required finish", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic on unsigned and signed views of the operands.
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic cin, input logic sub, input int stamp);
      exp_t   e;
      longint ua, ub, sa, sb, r, sr, lim;
      ua  = longint'(a);
      ub  = longint'(b);
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      lim = longint'(1) << W;
      if (sub) begin
         r    = ua - ub - longint'(cin);
         sr   = sa - sb - longint'(cin);
         e.cy = (r >= 0);
      end else begin
         r    = ua + ub + longint'(cin);
         sr   = sa + sb + longint'(cin);
         e.cy = (r >= lim);
      end
      e.sum   = r[W-1:0];
      e.ov    = (sr >= lim / 2) || (sr < -(lim / 2));
      e.stamp = stamp;
      return e;
   endfunction

   // Monitor: hold checks, pop/compare on consumption, then record newly accepted ops.
   always @(negedge Clock_In) begin
      if (rst_evt) begin
         rst_evt = 0;
      end else if (frozen_prev) begin
         chk("hold_valid", Valid_Out, hold_vld);
         chk("hold_sum", Sum_Out, hold_sum);
         chk("hold_carry", Carry_Out, hold_cy);
         chk("hold_ovf", Overflow_Out, hold_ov);
      end
      if (Reset_n_In && Valid_Out && Ready_In && Enable_In) begin
         if (sbq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_out: got sum 0x%0h with no pending op, required no output", Sum_Out);
         end else begin
            mon_e = sbq.pop_front();
            chk("sum", Sum_Out, mon_e.sum);
            chk("carry", Carry_Out, mon_e.cy);
            chk("ovf", Overflow_Out, mon_e.ov);
            if (lat_chk) chk("latency", cyc - mon_e.stamp, ST);
         end
      end
      if (Reset_n_In && Valid_In && Ready_Out)
         sbq.push_back(model(Data_A_In, Data_B_In, Carry_In, Sub_In, cyc));
      frozen_prev = Reset_n_In && (!Enable_In || (Valid_Out && !Ready_In));
      hold_vld    = Valid_Out;
      hold_sum    = Sum_Out;
      hold_cy     = Carry_Out;
      hold_ov     = Overflow_Out;
   end

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
      bit acc = 0;
      Data_A_In = a;
      Data_B_In = b;
      Carry_In  = cin;
      Sub_In    = sub;
      Valid_In  = 1'b1;
      for (int i = 0; i < 100 && !acc; i++) begin
         @(negedge Clock_In);
         acc = Ready_Out;
         if (exp_rdy) chk("ready_stream", Ready_Out, 1);
         @(posedge Clock_In);
         #1;
      end
      if (!acc) begin
         n_chk++;
         n_fail++;
         $display("FAIL send_timeout: got no acceptance in 100 cycles, required acceptance");
      end
   endtask

   task automatic send_rand();
      send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
   endtask

   task automatic send_n(input int n);
      for (int i = 0; i < n; i++) send_rand();
      Valid_In = 1'b0;
   endtask

   task automatic idle(input int n);
      Valid_In = 1'b0;
      repeat (n) begin
         @(posedge Clock_In);
         #1;
      end
   endtask

   task automatic drain();
      Valid_In = 1'b0;
      for (int i = 0; i < 200 && sbq.size() != 0; i++) begin
         @(posedge Clock_In);
         #1;
      end
      chk("drain_pending", sbq.size(), 0);
   endtask

   task automatic expect_out(input string name, input logic [W-1:0] sum, input logic cy, input logic ov);
      for (int i = 0; i < 10; i++) begin
         @(negedge Clock_In);
         if (Valid_Out) break;
      end
      chk({name, "_valid"}, Valid_Out, 1);
      chk({name, "_sum"}, Sum_Out, sum);
      chk({name, "_carry"}, Carry_Out, cy);
      chk({name, "_ovf"}, Overflow_Out, ov);
   endtask

   initial begin
      Reset_n_In = 1'b0;
      Enable_In  = 1'b1;
      Ready_In   = 1'b1;
      Valid_In   = 1'b0;
      Data_A_In  = '0;
      Data_B_In  = '0;
      Carry_In   = 1'b0;
      Sub_In     = 1'b0;
      repeat (3) @(posedge Clock_In);
      @(negedge Clock_In);
      chk("reset_valid", Valid_Out, 0);
      chk("reset_sum", Sum_Out, 0);
      chk("reset_carry", Carry_Out, 0);
      chk("reset_ovf", Overflow_Out, 0);
      @(posedge Clock_In);
      #1;
      Reset_n_In = 1'b1;
      idle(2);

      // Directed boundary cases with exact latency.
      lat_chk = 1;
      send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
      Valid_In = 1'b0;
      expect_out("wrap", 16'h0000, 1'b1, 1'b0);
      send(16'h8000, 16'h0001, 1'b0, 1'b1);
      Valid_In = 1'b0;
      expect_out("sub_ovf", 16'h7FFF, 1'b1, 1'b1);
      drain();

      // Back-to-back streaming, ready always high.
      exp_rdy = 1;
      send_n(100);
      exp_rdy = 0;
      drain();
      lat_chk = 0;

      // Backpressure: hold off the consumer for 3 cycles once results appear.
      fork
         send_n(12);
         begin
            bit seen = 0;
            for (int i = 0; i < 50 && !seen; i++) begin
               @(negedge Clock_In);
               seen = Valid_Out;
            end
            chk("bp_first_valid", seen, 1);
            @(posedge Clock_In);
            #1;
            Ready_In = 1'b0;
            repeat (3) begin
               @(negedge Clock_In);
               chk("ready_stall", Ready_Out, 0);
            end
            @(posedge Clock_In);
            #1;
            Ready_In = 1'b1;
         end
      join
      drain();

      // Enable freeze mid-stream for 5 cycles with the consumer ready.
      fork
         send_n(20);
         begin
            repeat (6) @(posedge Clock_In);
            #1;
            Enable_In = 1'b0;
            repeat (5) begin
               @(negedge Clock_In);
               chk("ready_frozen", Ready_Out, 0);
            end
            @(posedge Clock_In);
            #1;
            Enable_In = 1'b1;
         end
      join
      drain();

      // Mixed traffic: random bubbles, random consumer stalls and freezes.
      done = 0;
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               idle(int'($urandom % 3));
               send_rand();
            end
            Valid_In = 1'b0;
            done = 1;
         end
         begin
            while (!done) begin
               @(posedge Clock_In);
               #1;
               Ready_In  = ($urandom % 4) != 0;
               Enable_In = ($urandom % 8) != 0;
            end
            Ready_In  = 1'b1;
            Enable_In = 1'b1;
         end
      join
      drain();

      // Reset pulse with three ops in flight, the oldest already at the output.
      send_rand();
      send_rand();
      send_rand();
      Valid_In = 1'b0;
      @(posedge Clock_In);
      #1;
      chk("pre_reset_valid", Valid_Out, 1);
      #1;
      Reset_n_In = 1'b0;
      rst_evt    = 1;
      #1;
      chk("async_reset_valid", Valid_Out, 0);
      chk("async_reset_sum", Sum_Out, 0);
      chk("async_reset_carry", Carry_Out, 0);
      chk("async_reset_ovf", Overflow_Out, 0);
      sbq.delete();
      #1;
      Reset_n_In = 1'b1;
      repeat (10) begin
         @(negedge Clock_In);
         chk("no_stale", Valid_Out, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
